// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO word and depth definitions
package fifo_pkg;
    localparam int WORD_WIDTH    = 32;
    localparam int FIFO_DEPTH    = 4;
    localparam int DEF_BUF_DEPTH = 3;

    typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - circular output buffer with occupancy count
module stream_buf #(
    parameter int  DEPTH = 3,
    parameter int  WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign do_pop    = pop & !empty;
    assign do_push   = push & (!full | do_pop);
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_push) begin
                tail <= next_ptr(tail);
            end
            if (do_pop) begin
                head <= next_ptr(head);
            end
            if (do_push && !do_pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!do_push && do_pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a registered-read FIFO into a valid/ready stream
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = WORD_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic                 fifo_cs,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 overflow
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit_used;
    logic             buf_full;
    logic             buf_empty;
    logic             pop;

    // A read is only requested when a slot is guaranteed for the returning word.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign fifo_rd_en  = rst & enable & !fifo_empty
                       & (credit_used < (OCC_W + 1)'(BUF_DEPTH));
    assign fifo_cs     = rst;
    assign m_valid     = !buf_empty;
    assign pop         = m_valid & m_ready;

    stream_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= 1'b0;
            rd_count <= '0;
            overflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            if (inflight && buf_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
